// File: rtl/npc_exec_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : npc_exec_ctrl_if
// Description : Instruction-memory fetch interface between the NPC sequencer
//               and the simulation memory. It has two channels. The request
//               channel carries valid, ready and addr. The response channel
//               carries valid, ready, data and err.
//               master : sequencer side (drives request, accepts response)
//               slave  : memory side    (accepts request, drives response)
// Revision    : 1.0 - initial release
// ============================================================================
interface npc_exec_ctrl_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic        imem_rsp_ready;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;

    modport master (
        output imem_req_valid,
        input  imem_req_ready,
        output imem_req_addr,
        input  imem_rsp_valid,
        output imem_rsp_ready,
        input  imem_rsp_data,
        input  imem_rsp_err
    );

    modport slave (
        input  imem_req_valid,
        output imem_req_ready,
        input  imem_req_addr,
        output imem_rsp_valid,
        input  imem_rsp_ready,
        output imem_rsp_data,
        output imem_rsp_err
    );
endinterface
`default_nettype wire

// File: rtl/npc_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : npc_exec_ctrl
// Description : Multi-cycle sequencer for the NPC decode/execute datapath.
//               It owns the PC and fetches one instruction at a time over
//               imem. It presents a stable pc/inst pair to the datapath for
//               exactly one EXEC cycle, and halts on ebreak or on a fault.
//               Faults are a fetch error, a fetch timeout or a misaligned
//               next PC.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               imem (master)       - fetch request/response handshake
//               exec_pc/exec_inst   - pc/inst presented to the datapath
//               exec_dnpc           - next PC from the datapath
//               exec_wen, commit    - one-cycle pulses per retired instruction
//               halted, trap        - sticky halt, and halt-by-fault flag
//               cycle_cnt, instret  - performance counters (optional)
// Options     : define NPC_PERF_CNT_EN to add the cycle_cnt/instret counters
// Revision    : 1.0 - initial release
// ============================================================================
module npc_exec_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [7:0]  TIMEOUT  = 8'd255,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  wire logic        clk,
    input  wire logic        rst,
    npc_exec_ctrl_if.master  imem,
    output logic [31:0]      exec_pc,
    output logic [31:0]      exec_inst,
    input  wire logic [31:0] exec_dnpc,
    output logic             exec_wen,
    output logic             commit,
    output logic             halted,
    output logic             trap
`ifdef NPC_PERF_CNT_EN
    ,
    output logic [63:0]      cycle_cnt,
    output logic [63:0]      instret
`endif
);

    localparam logic [1:0]  c_ST_FETCH_REQ  = 2'd0;
    localparam logic [1:0]  c_ST_FETCH_WAIT = 2'd1;
    localparam logic [1:0]  c_ST_EXEC       = 2'd2;
    localparam logic [1:0]  c_ST_HALT       = 2'd3;
    localparam logic [31:0] c_EBREAK        = 32'h0010_0073;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic [7:0]  r_wdog;
    logic        r_trap;

    logic [1:0]  w_state_nxt;
    logic        w_set_trap;
    logic        w_pc_adv;
    logic        w_ld_inst;
    logic        w_timeout;

    // The watchdog fires on the TIMEOUT-th consecutive empty wait cycle.
    // A response in that same cycle is still taken, because the response
    // branch is checked before this flag.
    assign w_timeout = (TIMEOUT != 8'd0) && (r_wdog == (TIMEOUT - 8'd1));

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_FETCH_REQ;
            r_pc    <= RESET_PC;
            r_inst  <= NOP_INST;
            r_wdog  <= 8'd0;
            r_trap  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_trap  <= r_trap | w_set_trap;
            if (w_pc_adv)
                r_pc <= exec_dnpc;
            if (w_ld_inst)
                r_inst <= imem.imem_rsp_data;
            if ((r_state == c_ST_FETCH_WAIT) && !imem.imem_rsp_valid)
                r_wdog <= r_wdog + 8'd1;
            else
                r_wdog <= 8'd0;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_nxt = r_state;
        w_set_trap  = 1'b0;
        w_pc_adv    = 1'b0;
        w_ld_inst   = 1'b0;
        case (r_state)
            c_ST_FETCH_REQ: begin
                if (imem.imem_req_ready)
                    w_state_nxt = c_ST_FETCH_WAIT;
            end
            c_ST_FETCH_WAIT: begin
                if (imem.imem_rsp_valid) begin
                    if (imem.imem_rsp_err) begin
                        w_state_nxt = c_ST_HALT;
                        w_set_trap  = 1'b1;
                    end else begin
                        w_state_nxt = c_ST_EXEC;
                        w_ld_inst   = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_state_nxt = c_ST_HALT;
                    w_set_trap  = 1'b1;
                end
            end
            c_ST_EXEC: begin
                // The pc is left on the halting instruction so the
                // environment can inspect it after the halt.
                if (r_inst == c_EBREAK) begin
                    w_state_nxt = c_ST_HALT;
                end else if (exec_dnpc[1:0] != 2'b00) begin
                    w_state_nxt = c_ST_HALT;
                    w_set_trap  = 1'b1;
                end else begin
                    w_state_nxt = c_ST_FETCH_REQ;
                    w_pc_adv    = 1'b1;
                end
            end
            c_ST_HALT: begin
                w_state_nxt = c_ST_HALT;
            end
            default: begin
                w_state_nxt = c_ST_FETCH_REQ;
            end
        endcase
    end

    // ---------------- output logic ----------------
    // Outputs are masked while rst is high so that nothing leaks from the
    // pre-reset state during the reset cycle.
    always_comb begin
        imem.imem_req_valid = 1'b0;
        imem.imem_rsp_ready = 1'b0;
        imem.imem_req_addr  = r_pc;
        exec_pc             = r_pc;
        exec_inst           = NOP_INST;
        exec_wen            = 1'b0;
        commit              = 1'b0;
        halted              = 1'b0;
        trap                = r_trap & ~rst;
        if (!rst) begin
            case (r_state)
                c_ST_FETCH_REQ:  imem.imem_req_valid = 1'b1;
                c_ST_FETCH_WAIT: imem.imem_rsp_ready = 1'b1;
                c_ST_EXEC: begin
                    exec_inst = r_inst;
                    exec_wen  = 1'b1;
                    commit    = 1'b1;
                end
                c_ST_HALT:       halted = 1'b1;
                default:         halted = 1'b0;
            endcase
        end
    end

`ifdef NPC_PERF_CNT_EN
    logic [63:0] r_cycle_cnt;
    logic [63:0] r_instret;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycle_cnt <= 64'd0;
            r_instret   <= 64'd0;
        end else begin
            if (r_state != c_ST_HALT)
                r_cycle_cnt <= r_cycle_cnt + 64'd1;
            if (r_state == c_ST_EXEC)
                r_instret <= r_instret + 64'd1;
        end
    end

    assign cycle_cnt = r_cycle_cnt;
    assign instret   = r_instret;
`endif

endmodule
`default_nettype wire

// File: tb/tb_npc_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_npc_exec_ctrl
// Description : Self-checking bench for npc_exec_ctrl. It contains a memory
//               model with a configurable ready stall, response delay, error
//               and blocked address. A datapath model computes dnpc as pc+4,
//               or a fixed misaligned target for the jal opcode. A commit
//               scoreboard holds the expected pc, inst and cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_npc_exec_ctrl;
    localparam logic [31:0] c_RESET_PC = 32'h8000_0000;
    localparam logic [31:0] c_NOP      = 32'h0000_0013;
    localparam logic [31:0] c_EBREAK   = 32'h0010_0073;
    localparam logic [31:0] c_ADDI     = 32'h0050_0093;
    localparam logic [31:0] c_JAL      = 32'h1020_006f;
    localparam logic [31:0] c_JAL_TGT  = 32'h8000_0102;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    npc_exec_ctrl_if imem ();
    logic [31:0] exec_pc, exec_inst, exec_dnpc;
    logic        exec_wen, commit, halted, trap;
`ifdef NPC_PERF_CNT_EN
    logic [63:0] cycle_cnt, instret;
`endif

    npc_exec_ctrl #(
        .RESET_PC (c_RESET_PC),
        .TIMEOUT  (8'd8),
        .NOP_INST (c_NOP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .imem      (imem),
        .exec_pc   (exec_pc),
        .exec_inst (exec_inst),
        .exec_dnpc (exec_dnpc),
        .exec_wen  (exec_wen),
        .commit    (commit),
        .halted    (halted),
        .trap      (trap)
`ifdef NPC_PERF_CNT_EN
        ,
        .cycle_cnt (cycle_cnt),
        .instret   (instret)
`endif
    );

    assign exec_dnpc = (exec_inst == c_JAL) ? c_JAL_TGT : exec_pc + 32'd4;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- memory model ----------------
    logic [31:0] mem [logic [31:0]];
    int          stall_ready = 0;
    int          rsp_delay   = 0;
    bit          err_mode    = 1'b0;
    logic [31:0] block_addr  = 32'hffff_ffff;
    bit          pending     = 1'b0;
    logic [31:0] p_addr      = 32'd0;
    int          stall_cnt   = 0;
    int          wait_cnt    = 0;
    int          fetch_cnt   = 0;
    int          wen_cnt     = 0;
    int          cyc         = 0;

    initial begin
        imem.imem_req_ready = 1'b0;
        imem.imem_rsp_valid = 1'b0;
        imem.imem_rsp_data  = 32'd0;
        imem.imem_rsp_err   = 1'b0;
    end

    // Cycle 1 is the first cycle after the edge that sampled rst high.
    always @(posedge clk) begin
        if (rst) begin
            pending   = 1'b0;
            stall_cnt = 0;
            wait_cnt  = 0;
            cyc       = 1;
        end else begin
            cyc = cyc + 1;
            if (pending && imem.imem_rsp_valid && imem.imem_rsp_ready)
                pending = 1'b0;
            else if (pending)
                wait_cnt++;
            if (imem.imem_req_valid && imem.imem_req_ready) begin
                pending   = 1'b1;
                p_addr    = imem.imem_req_addr;
                wait_cnt  = 0;
                stall_cnt = 0;
                fetch_cnt++;
            end
        end
    end

    always @(negedge clk) begin
        if (imem.imem_req_valid) begin
            if (stall_cnt < stall_ready) begin
                imem.imem_req_ready = 1'b0;
                stall_cnt++;
            end else begin
                imem.imem_req_ready = 1'b1;
            end
        end else begin
            imem.imem_req_ready = 1'b0;
        end
        if (pending && (p_addr != block_addr) && (wait_cnt >= rsp_delay)) begin
            imem.imem_rsp_valid = 1'b1;
            imem.imem_rsp_data  = mem.exists(p_addr) ? mem[p_addr] : c_EBREAK;
            imem.imem_rsp_err   = err_mode;
        end else begin
            imem.imem_rsp_valid = 1'b0;
            imem.imem_rsp_data  = 32'd0;
            imem.imem_rsp_err   = 1'b0;
        end
        if (exec_wen)
            wen_cnt++;
    end

    // ---------------- commit scoreboard ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    always @(negedge clk) begin
        #1;
        if (commit) begin
            chk("commit_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("commit_pc", 64'(exec_pc), 64'(e.pc));
                chk("commit_inst", 64'(exec_inst), 64'(e.inst));
                chk("commit_wen", 64'(exec_wen), 64'd1);
                chk("commit_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic reset_dut();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_req_valid", 64'(imem.imem_req_valid), 64'd0);
        chk("rst_rsp_ready", 64'(imem.imem_rsp_ready), 64'd0);
        chk("rst_exec_pc", 64'(exec_pc), 64'(c_RESET_PC));
        chk("rst_exec_inst", 64'(exec_inst), 64'(c_NOP));
        chk("rst_halted_trap", {62'd0, halted, trap}, 64'd0);
        chk("rst_commit_wen", {62'd0, commit, exec_wen}, 64'd0);
        rst = 1'b0;
    endtask

    // Land on negedge+1 of the requested cycle; bounded in case cyc stalls.
    task automatic wait_cyc(input int n);
        int guard;
        guard = 0;
        do begin
            @(negedge clk);
            #1;
            guard++;
        end while ((cyc < n) && (guard < 500));
        chk("wait_cycle_reached", 64'(cyc), 64'(n));
    endtask

    initial begin
        // Scenario 1: addi then ebreak with zero-wait memory.
        mem.delete();
        mem[c_RESET_PC]         = c_ADDI;
        mem[c_RESET_PC + 32'd4] = c_EBREAK;
        fetch_cnt = 0;
        sb.push_back('{c_RESET_PC, c_ADDI, 3});
        sb.push_back('{c_RESET_PC + 32'd4, c_EBREAK, 6});
        reset_dut();
`ifdef NPC_PERF_CNT_EN
        chk("perf_rst_cycle", cycle_cnt, 64'd0);
        chk("perf_rst_instret", instret, 64'd0);
`endif
        wait_cyc(1);
        chk("s1_req_valid_c1", 64'(imem.imem_req_valid), 64'd1);
        wait_cyc(4);
        chk("s1_req_addr_2nd", 64'(imem.imem_req_addr), 64'(c_RESET_PC + 32'd4));
        wait_cyc(6);
        chk("s1_not_halted_c6", 64'(halted), 64'd0);
        wait_cyc(7);
        chk("s1_halted", 64'(halted), 64'd1);
        chk("s1_trap", 64'(trap), 64'd0);
        chk("s1_exec_pc", 64'(exec_pc), 64'(c_RESET_PC + 32'd4));
        chk("s1_halt_outputs", {59'd0, imem.imem_req_valid, imem.imem_rsp_ready,
                                exec_wen, commit, 1'b0}, 64'd0);
        chk("s1_exec_inst_nop", 64'(exec_inst), 64'(c_NOP));
        chk("s1_fetches", 64'(fetch_cnt), 64'd2);
        chk("s1_sb_empty", 64'(sb.size()), 64'd0);
`ifdef NPC_PERF_CNT_EN
        chk("s1_instret", instret, 64'd2);
        chk("s1_cycle_cnt", cycle_cnt, 64'd6);
`endif

        // Scenario 2: request not accepted for 4 cycles.
        mem.delete();
        mem[c_RESET_PC] = c_EBREAK;
        stall_ready = 4;
        fetch_cnt   = 0;
        sb.push_back('{c_RESET_PC, c_EBREAK, 7});
        reset_dut();
        for (int i = 1; i <= 4; i++) begin
            wait_cyc(i);
            chk("s2_stall_valid", 64'(imem.imem_req_valid), 64'd1);
            chk("s2_stall_ready", 64'(imem.imem_req_ready), 64'd0);
            chk("s2_stall_addr", 64'(imem.imem_req_addr), 64'(c_RESET_PC));
        end
        wait_cyc(5);
        chk("s2_handshake", 64'(imem.imem_req_valid & imem.imem_req_ready), 64'd1);
        wait_cyc(8);
        chk("s2_halted", 64'(halted), 64'd1);
        chk("s2_trap", 64'(trap), 64'd0);
        chk("s2_fetches", 64'(fetch_cnt), 64'd1);
        chk("s2_sb_empty", 64'(sb.size()), 64'd0);
        stall_ready = 0;

        // Scenario 3: access fault on the first fetch.
        mem.delete();
        mem[c_RESET_PC] = c_ADDI;
        err_mode = 1'b1;
        reset_dut();
        wen_cnt = 0;
        wait_cyc(3);
        chk("s3_halted", 64'(halted), 64'd1);
        chk("s3_trap", 64'(trap), 64'd1);
        chk("s3_exec_pc", 64'(exec_pc), 64'(c_RESET_PC));
        wait_cyc(6);
        chk("s3_no_wen", 64'(wen_cnt), 64'd0);
        err_mode = 1'b0;

        // Scenario 4a: no response, watchdog expires after 8 wait cycles.
        block_addr = c_RESET_PC;
        reset_dut();
        wait_cyc(9);
        chk("s4a_not_halted_c9", 64'(halted), 64'd0);
        wait_cyc(10);
        chk("s4a_halted_c10", 64'(halted), 64'd1);
        chk("s4a_trap", 64'(trap), 64'd1);
        block_addr = 32'hffff_ffff;

        // Scenario 4b: response in the 8th wait cycle wins over the watchdog.
        mem.delete();
        mem[c_RESET_PC] = c_EBREAK;
        rsp_delay = 7;
        sb.push_back('{c_RESET_PC, c_EBREAK, 10});
        reset_dut();
        wait_cyc(9);
        chk("s4b_rsp_at_limit", 64'(imem.imem_rsp_valid & imem.imem_rsp_ready), 64'd1);
        chk("s4b_not_halted", 64'(halted), 64'd0);
        wait_cyc(11);
        chk("s4b_halted", 64'(halted), 64'd1);
        chk("s4b_trap", 64'(trap), 64'd0);
        chk("s4b_sb_empty", 64'(sb.size()), 64'd0);
        rsp_delay = 0;

        // Scenario 5: jal to a misaligned target commits and then traps.
        mem.delete();
        mem[c_RESET_PC] = c_JAL;
        fetch_cnt = 0;
        sb.push_back('{c_RESET_PC, c_JAL, 3});
        reset_dut();
        wait_cyc(4);
        chk("s5_halted", 64'(halted), 64'd1);
        chk("s5_trap", 64'(trap), 64'd1);
        chk("s5_exec_pc", 64'(exec_pc), 64'(c_RESET_PC));
        wait_cyc(6);
        chk("s5_fetches", 64'(fetch_cnt), 64'd1);
        chk("s5_sb_empty", 64'(sb.size()), 64'd0);

        // Scenario 6: reset while waiting on the second fetch.
        mem.delete();
        mem[c_RESET_PC] = c_ADDI;
        block_addr = c_RESET_PC + 32'd4;
        sb.push_back('{c_RESET_PC, c_ADDI, 3});
        reset_dut();
        wait_cyc(5);
        chk("s6_in_wait", 64'(imem.imem_rsp_ready), 64'd1);
        chk("s6_pc_before_rst", 64'(exec_pc), 64'(c_RESET_PC + 32'd4));
        reset_dut();
        wait_cyc(1);
        chk("s6_req_valid", 64'(imem.imem_req_valid), 64'd1);
        chk("s6_req_addr", 64'(imem.imem_req_addr), 64'(c_RESET_PC));
        chk("s6_halted", 64'(halted), 64'd0);
        chk("s6_sb_empty", 64'(sb.size()), 64'd0);
`ifdef NPC_PERF_CNT_EN
        chk("s6_cycle_cnt", cycle_cnt, 64'd0);
        chk("s6_instret", instret, 64'd0);
`endif
        block_addr = 32'hffff_ffff;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
